mux32_arbiter: RTL and testbench
================================

MUX32_ARBITER -- requirements
Module: mux32_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum cycles a grant is held before forced release (used only with MUX32_ARBITER_TIMEOUT_EN), legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  32  request vector; bit i = requester i wants the shared mux32 output.
REQ-005 SHALL have port done  input  1  owner finished this transfer; sampled only while a grant is active.
REQ-006 SHALL have port grant  output  32  one-hot grant; all-zero when no owner.
REQ-007 SHALL have port select  output  5  mux32 select; equals the index of the set grant bit while valid=1.
REQ-008 SHALL have port valid  output  1  high while a grant is active.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and BUSY (one owner).
REQ-011 SHALL keep a 5-bit round-robin pointer ptr: the highest-priority index for the next arbitration.
REQ-012 IDLE, req != 0: SHALL move to BUSY next edge, granting the first set req bit found scanning ptr, ptr+1, ... mod 32.
REQ-013 IDLE, req == 0: SHALL remain in IDLE with grant=0, valid=0; select holds its last value.
REQ-014 Grant latency SHALL be exactly one cycle from req sampled high in IDLE to valid=1.
REQ-015 BUSY: grant, select and valid SHALL stay constant regardless of other req bits.
REQ-016 BUSY SHALL return to IDLE next edge when done=1 or req[select]=0; grant and valid drop on that edge.
REQ-017 On every release SHALL set ptr = select+1, wrapping 31 -> 0.
REQ-018 At least one IDLE cycle SHALL separate consecutive grants (mux settling gap).
REQ-019 done sampled in IDLE SHALL be ignored.
REQ-020 done=1 and req[select]=0 in the same cycle SHALL cause a single normal release (timeout stays 0).
REQ-021 grant SHALL never have more than one bit set; select SHALL always be 0..31.

Reset
REQ-022 rst=0 SHALL immediately, independent of clk, force state=IDLE, ptr=0, grant=0, select=0, valid=0, timeout=0, hold counter=0.
REQ-023 Reset asserted during BUSY SHALL abort the grant without a timeout pulse; after rst returns to 1, arbitration restarts from ptr=0.

Configuration
REQ-024 Macro MUX32_ARBITER_TIMEOUT_EN defined: SHALL include an 8-bit hold counter cleared on entry to BUSY and incremented each BUSY cycle.
REQ-025 With the macro, if the owner has been granted for MAX_HOLD cycles without release, SHALL force BUSY -> IDLE, pulse timeout=1 for one cycle, and advance ptr per REQ-017.
REQ-026 With the macro, a done or req drop in the same cycle the limit is reached SHALL count as a normal release (timeout stays 0).
REQ-027 Macro not defined: SHALL contain no hold counter, timeout SHALL be tied 0, and MAX_HOLD SHALL be ignored.

Verification
REQ-028 Reset, then req=32'h0000_0001 -> one cycle later valid=1, select=0, grant=32'h1; done pulse -> next cycle valid=0, ptr=1.
REQ-029 req=32'h8000_0001 held, done pulsed one cycle after each grant -> select sequence 0, 31, 0, 31 with one IDLE cycle between grants.
REQ-030 ptr=31 after a release of 30, req=32'h0000_0004 -> select=2 (wrap-around scan).
REQ-031 Owner 5 granted, req[5] drops with done=0 -> release next edge; req=32'h0000_0060 -> next grant select=6.
REQ-032 Macro defined, MAX_HOLD=4, req=32'h0000_0008 held, done=0 -> valid high for 4 cycles, timeout=1 for exactly one cycle at release; macro undefined -> valid stays high, timeout stays 0.
REQ-033 rst driven low mid-BUSY, between clk edges -> grant, valid, select read 0 immediately; after rst=1 with req=32'hFFFF_FFFF, first grant is select=0.

Source files
------------

// File: rtl/mux32_arbiter.sv
// mux32_arbiter: round-robin owner selection for a shared 32:1 mux.
// One owner at a time; at least one idle cycle between owners so the mux can
// settle. Optional forced release after MAX_HOLD cycles when the macro
// MUX32_ARBITER_TIMEOUT_EN is defined; otherwise timeout is tied low.
//
//   state | meaning
//   IDLE  | no owner, scanning req from ptr for the next grant
//   BUSY  | one owner holds the mux, waiting for done / req drop / limit

module mux32_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        done,
    output logic [31:0] grant,
    output logic [4:0]  select,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [4:0] ptr, ptr_next;
    logic [4:0] select_next;
    logic       found;
    logic [4:0] pick;
    logic [4:0] idx;
    logic       normal_release;
    logic       rel_now;

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
            $error("mux32_arbiter: MAX_HOLD must be within 2..255");
        end
    endgenerate

    // Round-robin scan: first set req bit at ptr, ptr+1, ... wrapping at 32.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int i = 0; i < 32; i++) begin
            idx = ptr + 5'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // done or a dropped request both end the transfer; done in IDLE is ignored.
    assign normal_release = (state == BUSY) && (done || !req[select]);

`ifdef MUX32_ARBITER_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       forced_release;

    // Forced release only when no normal release happens in the same cycle.
    assign forced_release = (state == BUSY) && !normal_release &&
                            (hold_cnt == 8'(MAX_HOLD - 1));
    assign rel_now        = normal_release || forced_release;

    // Hold counter: cleared on grant, counts cycles spent in BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Timeout pulse is high for the single cycle after a forced release edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= forced_release;
        end
    end
`else
    assign rel_now = normal_release;
    assign timeout = 1'b0;
`endif

    // Next-state and pointer/select update.
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        select_next = select;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next  = BUSY;
                    select_next = pick;
                end
            end
            BUSY: begin
                if (rel_now) begin
                    state_next = IDLE;
                    ptr_next   = select + 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointer and select registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            select <= '0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            select <= select_next;
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    assign valid = (state == BUSY);
    assign grant = valid ? (32'd1 << select) : 32'd0;

endmodule

// File: tb/tb_mux32_arbiter.sv
// Bench for mux32_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against an owner/pointer model of the arbitration rules.
// Timeout expectations follow MUX32_ARBITER_TIMEOUT_EN.

module tb_mux32_arbiter;

    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req = '0;
    logic        done = 1'b0;
    logic [31:0] grant;
    logic [4:0]  select;
    logic        valid;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    mux32_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .select  (select),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the mux, where the next scan starts.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 32; k++) begin
                    int n;
                    n = (m_ptr + k) % 32;
                    if (m_owner < 0 && req[n]) begin
                        m_owner = n;
                        m_sel   = n;
                        m_hold  = 0;
                    end
                end
            end else if (done || !req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 32;
                m_owner = -1;
            end else begin
`ifdef MUX32_ARBITER_TIMEOUT_EN
                if (m_hold + 1 >= int'(HOLD)) begin
                    m_ptr   = (m_owner + 1) % 32;
                    m_owner = -1;
                    m_to    = 1'b1;
                end else begin
                    m_hold = m_hold + 1;
                end
`else
                m_hold = m_hold + 1;
`endif
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_grant;
        exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("grant", grant, exp_grant);
        chk("valid", {31'd0, valid}, {31'd0, m_owner >= 0});
        chk("select", {27'd0, select}, 32'(m_sel));
        chk("timeout", {31'd0, timeout}, {31'd0, m_to});
        chk("onehot", {31'd0, $onehot0(grant)}, 32'd1);
    endtask

    // One cycle: check what the last edge produced, then drive the next inputs.
    task automatic cyc(input logic [31:0] r, input logic d);
        @(negedge clk);
        check_outputs();
        req  = r;
        done = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        req  = '0;
        done = 1'b0;
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
    endtask

    initial begin
        int seq[4];
        int nseq;
        int run;
        int pulses;
        bit counting;
        logic [31:0] r;

        // Reset state and first grant.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_select", {27'd0, select}, 32'd0);
        rst = 1'b1;

        cyc(32'h1, 1'b0);
        cyc(32'h1, 1'b1);
        chk("first_grant", grant, 32'h1);
        cyc(32'h0, 1'b0);
        chk("first_release", {31'd0, valid}, 32'd0);
        cyc(32'h2, 1'b0);
        cyc(32'h3, 1'b0);
        chk("ptr_after_0", {27'd0, select}, 32'd1);

        // Alternating 0 / 31 with one idle cycle between owners.
        do_reset();
        nseq = 0;
        req = 32'h8000_0001;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_outputs();
            done = 1'b0;
            if (valid && nseq < 4) begin
                seq[nseq] = int'(select);
                nseq++;
                done = 1'b1;
            end
        end
        chk("alt_count", 32'(nseq), 32'd4);
        chk("alt_0", 32'(seq[0]), 32'd0);
        chk("alt_1", 32'(seq[1]), 32'd31);
        chk("alt_2", 32'(seq[2]), 32'd0);
        chk("alt_3", 32'(seq[3]), 32'd31);

        // Wrap-around scan after releasing owner 30.
        do_reset();
        cyc(32'h4000_0000, 1'b0);
        cyc(32'h4000_0000, 1'b1);
        cyc(32'h0000_0004, 1'b0);
        cyc(32'h0000_0004, 1'b0);
        chk("wrap_sel", {27'd0, select}, 32'd2);

        // Request drop releases; scan resumes at 6.
        do_reset();
        cyc(32'h20, 1'b0);
        cyc(32'h0, 1'b0);
        cyc(32'h60, 1'b0);
        cyc(32'h60, 1'b0);
        chk("drop_sel", {27'd0, select}, 32'd6);

        // Held request with no done.
        do_reset();
        cyc(32'h8, 1'b0);
        run = 0;
        pulses = 0;
        counting = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc(32'h8, 1'b0);
            if (valid && counting) run++;
            if (!valid) counting = 1'b0;
            if (timeout) pulses++;
        end
`ifdef MUX32_ARBITER_TIMEOUT_EN
        chk("hold_run", 32'(run), HOLD);
        chk("hold_pulses", 32'(pulses), 32'd1);
`else
        chk("hold_run", 32'(run), 32'd8);
        chk("hold_pulses", 32'(pulses), 32'd0);
`endif

        // Asynchronous reset in the middle of a grant.
        do_reset();
        cyc(32'h80, 1'b0);
        cyc(32'h80, 1'b0);
        cyc(32'h80, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_grant", grant, 32'd0);
        chk("async_valid", {31'd0, valid}, 32'd0);
        chk("async_select", {27'd0, select}, 32'd0);
        chk("async_timeout", {31'd0, timeout}, 32'd0);
        cyc(32'hFFFF_FFFF, 1'b0);
        rst = 1'b1;
        cyc(32'hFFFF_FFFF, 1'b0);
        cyc(32'hFFFF_FFFF, 1'b0);
        chk("restart_sel", {27'd0, select}, 32'd0);
        chk("restart_valid", {31'd0, valid}, 32'd1);

        // Random traffic.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 7))
                0: r = '0;
                1: r = 32'd1 << $urandom_range(0, 31);
                2: r = $urandom();
                3: r = r ^ (32'd1 << $urandom_range(0, 31));
                default: ;
            endcase
            cyc(r, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #1;
                chk("rand_async_valid", {31'd0, valid}, 32'd0);
                @(negedge clk);
                check_outputs();
                rst = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
